// File: rtl/logic_unit.sv
// Registered bitwise logic unit with accumulator chaining and valid/ready handshake.
// Status flags are built only when LOGIC_UNIT_FLAGS_EN is defined; otherwise they are tied to 0.
module logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_par
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             out_valid_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] f_s;
    logic             accept_s;

    // The output stage is one register that may be refilled on the same edge it is popped.
    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign y         = y_r;

    // Operand selection and the eight bitwise operations.
    always_comb begin
        x_s = chain ? acc_r : a;
        f_s = {WIDTH{1'b0}};
        case (op_e'(op))
            OP_AND:  f_s = x_s & b;
            OP_OR:   f_s = x_s | b;
            OP_XOR:  f_s = x_s ^ b;
            OP_NAND: f_s = ~(x_s & b);
            OP_NOR:  f_s = ~(x_s | b);
            OP_XNOR: f_s = ~(x_s ^ b);
            OP_ANDN: f_s = x_s & ~b;
            OP_PASS: f_s = x_s;
            default: f_s = x_s;
        endcase
    end

    // Result, accumulator and valid register; a stall simply holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            y_r         <= f_s;
            acc_r       <= f_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    function automatic logic zero_f(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    function automatic logic ones_f(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}});
    endfunction

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic flag_zero_r;
    logic flag_ones_r;
    logic flag_par_r;

    // Flags are computed from the new result so they land in the same edge as y.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero_r <= 1'b1;
            flag_ones_r <= 1'b0;
            flag_par_r  <= 1'b0;
        end else if (accept_s) begin
            flag_zero_r <= zero_f(f_s);
            flag_ones_r <= ones_f(f_s);
            flag_par_r  <= parity_f(f_s);
        end
    end

    assign flag_zero = flag_zero_r;
    assign flag_ones = flag_ones_r;
    assign flag_par  = flag_par_r;
`else
    assign flag_zero = 1'b0;
    assign flag_ones = 1'b0;
    assign flag_par  = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: stimulus pushes expected results, a monitor pops on each output pop.
module tb_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        chain;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        flag_zero;
    logic        flag_ones;
    logic        flag_par;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    logic [15:0] rst_a, rst_b;
    logic [15:0] v;
    int waits;

    logic_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .chain(chain), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .flag_zero(flag_zero), .flag_ones(flag_ones), .flag_par(flag_par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference flags {zero, ones, par} counted bit by bit.
    function automatic logic [2:0] exp_flags(input logic [15:0] r);
`ifdef LOGIC_UNIT_FLAGS_EN
        int cnt = 0;
        for (int i = 0; i < 16; i++) cnt += int'(r[i]);
        return {cnt == 0, cnt == 16, cnt % 2 == 1};
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [2:0] reset_flags();
`ifdef LOGIC_UNIT_FLAGS_EN
        return 3'b100;
`else
        return 3'b000;
`endif
    endfunction

    // Monitor: every pop seen by downstream must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {16'h0, y}, 32'hDEAD);
            end else begin
                v = exp_q.pop_front();
                chk("y", {16'h0, y}, {16'h0, v});
                chk("flags", {29'h0, flag_zero, flag_ones, flag_par}, {29'h0, exp_flags(v)});
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic c, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] ey, output int nw);
        bit done = 1'b0;
        in_valid = 1'b1; op = o; chain = c; a = av; b = bv;
        nw = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ey);
                done = 1'b1;
            end else begin
                nw++;
            end
        end
        if (!done) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [15:0] b2b_exp [8];

    initial begin
        b2b_exp = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h5555, 16'h5555};
        rst = 1'b1; in_valid = 1'b0; op = 3'b000; chain = 1'b0; a = 16'h0; b = 16'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_y", {16'h0, y}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_flags", {29'h0, flag_zero, flag_ones, flag_par}, {29'h0, reset_flags()});

        // First scenario: OR 0xFFFF | 0xAAAA, checked directly and via scoreboard.
        send(3'b001, 1'b0, 16'hFFFF, 16'hAAAA, 16'hFFFF, waits);
        chk("or_out_valid", {31'h0, out_valid}, 32'h1);
        chk("or_y_direct", {16'h0, y}, 32'hFFFF);
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("or_flags_direct", {29'h0, flag_zero, flag_ones, flag_par}, 32'h2);
`else
        chk("or_flags_direct", {29'h0, flag_zero, flag_ones, flag_par}, 32'h0);
`endif

        // All eight ops back to back; no wait cycles allowed.
        for (int k = 0; k < 8; k++) begin
            send(3'(k), 1'b0, 16'h5555, 16'hAAAA, b2b_exp[k], waits);
            chk("b2b_throughput", waits, 0);
        end
        send(3'b010, 1'b0, 16'h5555, 16'h5555, 16'h0000, waits);

        // Chaining through the accumulator.
        send(3'b111, 1'b0, 16'h000F, 16'h0000, 16'h000F, waits);
        send(3'b001, 1'b1, 16'hFFFF, 16'h00F0, 16'h00FF, waits);
        send(3'b010, 1'b1, 16'hFFFF, 16'h0001, 16'h00FE, waits);

        // Backpressure: stall with a pending chained input, then release.
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'b111, 1'b0, 16'h00A5, 16'h0000, 16'h00A5, waits);
        in_valid = 1'b1; op = 3'b001; chain = 1'b1; a = 16'hFFFF; b = 16'h0F00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_y", {16'h0, y}, 32'h00A5);
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'h0, in_ready}, 32'h1);
        exp_q.push_back(16'h0FA5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_y", {16'h0, y}, 32'h0FA5);

        // Reset while stalled drops the held result and clears acc.
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'b111, 1'b0, 16'hBEEF, 16'h0000, 16'hBEEF, waits);
        chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_y", {16'h0, y}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("midrst_flags", {29'h0, flag_zero, flag_ones, flag_par}, {29'h0, reset_flags()});
        out_ready = 1'b1;
        send(3'b001, 1'b1, 16'hFFFF, 16'h1234, 16'h1234, waits);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
